// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory port between two
// req/ack masters. Each access is serialized through IDLE -> ACCESS ->
// CAPTURE. Simultaneous requests are resolved round-robin against the
// master that was granted last.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,

  // master 0
  input  logic                  m0_req,
  input  logic                  m0_write,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  // master 1
  input  logic                  m1_req,
  input  logic                  m1_write,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  // memory side
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write,
  output logic [DATA_WIDTH-1:0] to_memory,
  input  logic [DATA_WIDTH-1:0] from_memory,

  // one-hot owner of the access in flight
  output logic [1:0]            grant
);

  // ---------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  // Master identifiers as stored in owner/last_grant.
  localparam logic       MST_M0     = 1'b0;
  localparam logic       MST_M1     = 1'b1;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [1:0]            state_q,      state_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
  logic                  is_write_q,   is_write_d;
  logic                  owner_q,      owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [1:0]            grant_q,      grant_d;
  logic                  m0_ack_q,     m0_ack_d;
  logic                  m1_ack_q,     m1_ack_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q,   m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q,   m1_rdata_d;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic m0_elig;
  logic m1_elig;
  logic any_elig;
  logic win_m1;

  // A master in its ack cycle is not eligible, so a req held across the
  // ack cannot issue a second access off the same handshake.
  assign m0_elig  = m0_req & ~m0_ack_q;
  assign m1_elig  = m1_req & ~m1_ack_q;
  assign any_elig = m0_elig | m1_elig;

  // m1 wins when it is alone, or on a tie when m0 was granted last.
  assign win_m1   = m1_elig & (~m0_elig | (last_grant_q == MST_M0));

  // ---------------------------------------------------------------------
  // Next-state logic: FSM, request capture, ack and read-data return
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    is_write_d   = is_write_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          // Register the winner's request so later changes on its inputs
          // cannot disturb the access in flight.
          if (win_m1) begin
            addr_d       = m1_address;
            wdata_d      = m1_wdata;
            is_write_d   = m1_write;
            owner_d      = MST_M1;
            last_grant_d = MST_M1;
            grant_d      = GRANT_M1;
          end else begin
            addr_d       = m0_address;
            wdata_d      = m0_wdata;
            is_write_d   = m0_write;
            owner_d      = MST_M0;
            last_grant_d = MST_M0;
            grant_d      = GRANT_M0;
          end
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        // Address/data/strobe are presented this cycle; read data comes
        // back from the synchronous memory during CAPTURE.
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        if (owner_q == MST_M1) begin
          m1_ack_d = 1'b1;
          if (!is_write_q) begin
            m1_rdata_d = from_memory;
          end
        end else begin
          m0_ack_d = 1'b1;
          if (!is_write_q) begin
            m0_rdata_d = from_memory;
          end
        end
        grant_d = GRANT_NONE;
        state_d = ST_IDLE;
      end

      default: begin
        // Unreachable encoding: recover to a clean idle.
        grant_d = GRANT_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers with synchronous reset
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      is_write_q   <= 1'b0;
      owner_q      <= MST_M0;
      last_grant_q <= MST_M1;  // m0 wins the first tie after reset
      grant_q      <= GRANT_NONE;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      is_write_q   <= is_write_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // The strobe is decoded from registered state only, so it is exactly the
  // ACCESS cycle wide and drops on the same edge that a reset lands.
  assign write     = (state_q == ST_ACCESS) & is_write_q;
  assign address   = addr_q;
  assign to_memory = wdata_q;
  assign grant     = grant_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small synchronous
// memory model on the memory port. Outputs are sampled 1 time unit after
// each rising edge; inputs are changed at that same point.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_write;
  logic [AW-1:0] m0_address;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;
  logic          m1_req, m1_write;
  logic [AW-1:0] m1_address;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;
  logic [AW-1:0] address;
  logic          write;
  logic [DW-1:0] to_memory;
  logic [DW-1:0] from_memory;
  logic [1:0]    grant;

  int n_total = 0;
  int n_pass  = 0;
  int wr_cycles = 0;

  // preload path into the memory model
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] mem [256];

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .m0_req      (m0_req),
    .m0_write    (m0_write),
    .m0_address  (m0_address),
    .m0_wdata    (m0_wdata),
    .m0_ack      (m0_ack),
    .m0_rdata    (m0_rdata),
    .m1_req      (m1_req),
    .m1_write    (m1_write),
    .m1_address  (m1_address),
    .m1_wdata    (m1_wdata),
    .m1_ack      (m1_ack),
    .m1_rdata    (m1_rdata),
    .address     (address),
    .write       (write),
    .to_memory   (to_memory),
    .from_memory (from_memory),
    .grant       (grant)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data for the address seen at an edge is
  // available during the following cycle.
  always @(posedge clk) begin
    if (write === 1'b1)  mem[address] <= to_memory;
    else if (pl_en)      mem[pl_addr] <= pl_data;
    from_memory <= mem[address];
  end

  // Count write-strobe cycles.
  always @(posedge clk) begin
    if (write === 1'b1) wr_cycles <= wr_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  logic [3:0] cont_exp [12];  // {m1_ack, m0_ack, grant}
  logic [3:0] lone_exp [7];   // {m0_ack, m1_ack, grant}
  int         wr_before;

  initial begin
    cont_exp = '{4'b0001, 4'b0001, 4'b0100, 4'b0010, 4'b0010, 4'b1000,
                 4'b0001, 4'b0001, 4'b0100, 4'b0010, 4'b0010, 4'b1000};
    lone_exp = '{4'b0010, 4'b0010, 4'b0100, 4'b0000, 4'b0010, 4'b0010, 4'b0100};

    reset = 1'b1;
    m0_req = 1'b0; m0_write = 1'b0; m0_address = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_write = 1'b0; m1_address = '0; m1_wdata = '0;

    // Memory contents used by the reads, loaded while reset is held.
    preload(8'h3C, 8'hA5);
    preload(8'h10, 8'h11);
    preload(8'h20, 8'h22);
    do_reset();

    // ---- reset state, then idle ----
    check("rst_address",   32'(address),   32'h0);
    check("rst_to_memory", 32'(to_memory), 32'h0);
    check("rst_write",     32'(write),     32'h0);
    check("rst_acks",      32'({m0_ack, m1_ack}), 32'h0);
    check("rst_rdata",     32'({m0_rdata, m1_rdata}), 32'h0);
    check("rst_grant",     32'(grant),     32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_wr_grant", 32'({write, grant}), 32'h0);
    end

    // ---- m0 read from 0x3C ----
    m0_req = 1'b1; m0_write = 1'b0; m0_address = 8'h3C;
    step();  // ACCESS
    check("rd_acc_grant", 32'(grant),   32'h1);
    check("rd_acc_addr",  32'(address), 32'h3C);
    check("rd_acc_write", 32'(write),   32'h0);
    step();  // CAPTURE
    check("rd_cap_addr",  32'(address), 32'h3C);
    check("rd_cap_write", 32'(write),   32'h0);
    check("rd_cap_ack",   32'(m0_ack),  32'h0);
    step();  // ack cycle
    check("rd_ack",       32'({m1_ack, m0_ack}), 32'h1);
    check("rd_rdata",     32'(m0_rdata), 32'hA5);
    check("rd_grant_off", 32'(grant),    32'h0);
    m0_req = 1'b0;
    step();
    check("rd_ack_pulse", 32'(m0_ack),   32'h0);
    check("rd_rdata_hold", 32'(m0_rdata), 32'hA5);

    // ---- m1 write of 0x5A to 0x80 ----
    wr_before = wr_cycles;
    m1_req = 1'b1; m1_write = 1'b1; m1_address = 8'h80; m1_wdata = 8'h5A;
    step();  // ACCESS
    check("wr_acc_grant", 32'(grant),     32'h2);
    check("wr_acc_write", 32'(write),     32'h1);
    check("wr_acc_addr",  32'(address),   32'h80);
    check("wr_acc_data",  32'(to_memory), 32'h5A);
    // owner inputs changing after grant must not leak through
    m1_address = 8'h11; m1_wdata = 8'hFF;
    step();  // CAPTURE
    check("wr_cap_write", 32'(write),     32'h0);
    check("wr_cap_addr",  32'(address),   32'h80);
    step();  // ack cycle
    check("wr_ack",       32'({m1_ack, m0_ack}), 32'h2);
    check("wr_rdata_keep", 32'(m1_rdata), 32'h0);
    m1_req = 1'b0; m1_write = 1'b0;
    step();
    check("wr_strobe_cycles", 32'(wr_cycles - wr_before), 32'h1);
    check("wr_mem_80",    32'(mem[8'h80]), 32'h5A);
    check("wr_idle_addr", 32'(address),   32'h80);

    // ---- contention from reset: m0, m1, m0, m1 ----
    do_reset();
    m0_req = 1'b1; m0_write = 1'b0; m0_address = 8'h10;
    m1_req = 1'b1; m1_write = 1'b0; m1_address = 8'h20;
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("cont_c%0d", k + 1), 32'({m1_ack, m0_ack, grant}),
            32'(cont_exp[k]));
      if (k == 2) check("cont_m0_rdata", 32'(m0_rdata), 32'h11);
      if (k == 5) check("cont_m1_rdata", 32'(m1_rdata), 32'h22);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step();
    check("cont_end_grant", 32'(grant), 32'h0);

    // ---- lone m1 holding req across its ack: 4-cycle period ----
    m1_req = 1'b1; m1_write = 1'b0; m1_address = 8'h20;
    for (int k = 0; k < 7; k++) begin
      step();
      check($sformatf("lone_c%0d", k + 1), 32'({m0_ack, m1_ack, grant}),
            32'(lone_exp[k]));
    end
    m1_req = 1'b0;
    step();

    // ---- reset during ACCESS of a write ----
    m1_req = 1'b1; m1_write = 1'b1; m1_address = 8'h50; m1_wdata = 8'h99;
    step();  // ACCESS
    check("rmid_write_on", 32'(write), 32'h1);
    reset = 1'b1;
    step();
    check("rmid_write_drop", 32'(write),     32'h0);
    check("rmid_grant",      32'(grant),     32'h0);
    check("rmid_addr",       32'(address),   32'h0);
    check("rmid_data",       32'(to_memory), 32'h0);
    check("rmid_no_ack",     32'({m1_ack, m0_ack}), 32'h0);
    step();
    check("rmid_no_ack2",    32'({m1_ack, m0_ack}), 32'h0);
    // m1 pending alone after release: it is granted
    reset = 1'b0;
    step();
    check("rmid_m1_alone",   32'(grant), 32'h2);
    // reset again mid-access, now with m0 also pending: m0 wins the tie
    reset = 1'b1;
    m0_req = 1'b1; m0_write = 1'b0; m0_address = 8'h10;
    step();
    check("rmid2_write_drop", 32'(write), 32'h0);
    step();
    check("rmid2_no_ack",    32'({m1_ack, m0_ack}), 32'h0);
    reset = 1'b0;
    step();
    check("rmid2_tie_m0",    32'(grant), 32'h1);
    m1_req = 1'b0;
    step();
    step();
    check("rmid2_m0_ack",    32'({m1_ack, m0_ack}), 32'h1);
    check("rmid2_m0_rdata",  32'(m0_rdata), 32'h11);
    m0_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
